regfile_wr_arb: RTL and testbench

Write-port arbiter and sequencer for the 32×32 general-purpose register file. Up to NREQ writeback sources (WBU, multi-cycle MDU, late load return) share the single register-file write port through valid/ready handshakes. The block grants one source per cycle and registers the winning write onto `we`/`wAddr`/`wData`. It also publishes a pending-write mask so the IDU can stall on read-after-write hazards while writes are queued or in flight.

---
 rtl/regfile_wr_arb.sv | 122 ++++++++++++
 tb/tb_regfile_wr_arb.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arb.sv
// Register-file write-port arbiter: grants one of NREQ writeback sources per cycle,
// registers the winning write and publishes a pending-write mask. Define REGFILE_ARB_RR_EN for round-robin.
module regfile_wr_arb #(
   parameter int NREQ = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [5*NREQ-1:0]  req_addr,
   input  logic [32*NREQ-1:0] req_data,
   output logic               we,
   output logic [4:0]         wAddr,
   output logic [31:0]        wData,
   output logic [31:0]        pend_mask,
   output logic [NREQ-1:0]    last_grant
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0] grant;
   logic            xfer;
   logic [4:0]      sel_addr;
   logic [31:0]     sel_data;

   logic            we_q;
   logic [4:0]      waddr_q;
   logic [31:0]     wdata_q;
   logic [NREQ-1:0] lg_q;

`ifdef REGFILE_ARB_RR_EN
   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] gidx;

   // Scan from the pointer with wrap-around; the first valid requester wins.
   always_comb begin
      logic          found;
      logic [PW:0]   sum;
      logic [PW-1:0] idx;
      grant = '0;
      gidx  = '0;
      found = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, ptr_q} + (PW+1)'(k);
         if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
         idx = sum[PW-1:0];
         if (!found && req_valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            gidx       = idx;
         end
      end
   end

   assign ptr_d = (gidx == PW'(NREQ-1)) ? '0 : gidx + PW'(1);

   always_ff @(posedge clk) begin
      if (rst)       ptr_q <= '0;
      else if (xfer) ptr_q <= ptr_d;
   end
`else
   always_comb begin
      logic found;
      grant = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && req_valid[k]) begin
            found    = 1'b1;
            grant[k] = 1'b1;
         end
      end
   end
`endif

   // No handshake can complete while reset is asserted.
   assign req_ready = rst ? '0 : grant;
   assign xfer      = |req_ready;

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_addr = sel_addr | req_addr[i*5 +: 5];
            sel_data = sel_data | req_data[i*32 +: 32];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         lg_q    <= '0;
      end else begin
         we_q <= xfer && (sel_addr != 5'd0);
         if (xfer) begin
            waddr_q <= sel_addr;
            wdata_q <= sel_data;
            lg_q    <= grant;
         end
      end
   end

   // Queued writes plus the one sitting in the output register; $0 never counts.
   always_comb begin
      pend_mask = '0;
      for (int i = 0; i < NREQ; i++)
         if (req_valid[i]) pend_mask[req_addr[i*5 +: 5]] = 1'b1;
      if (we_q) pend_mask[waddr_q] = 1'b1;
      pend_mask[0] = 1'b0;
   end

   assign we         = we_q;
   assign wAddr      = waddr_q;
   assign wData      = wdata_q;
   assign last_grant = lg_q;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Directed bench for regfile_wr_arb (NREQ=3); expectations follow REGFILE_ARB_RR_EN when defined.
module tb_regfile_wr_arb;
   localparam int NREQ = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [5*NREQ-1:0] req_addr;
   logic [32*NREQ-1:0] req_data;
   logic              we;
   logic [4:0]        wAddr;
   logic [31:0]       wData;
   logic [31:0]       pend_mask;
   logic [NREQ-1:0]   last_grant;

   int n_pass  = 0;
   int n_total = 0;

   logic [31:0] rf [32];

   regfile_wr_arb #(.NREQ(NREQ)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .we(we), .wAddr(wAddr),
      .wData(wData), .pend_mask(pend_mask), .last_grant(last_grant)
   );

   always #5 clk = ~clk;

   // Architectural register file as the IDU would see it.
   always @(posedge clk) if (we) rf[wAddr] <= wData;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
      req_addr[i*5 +: 5]   = a;
      req_data[i*32 +: 32] = d;
   endtask

   initial begin
      logic [NREQ-1:0] exp_g;
      logic [4:0]      prev_a;
      int              n;

      rst = 1'b1;
      req_valid = '1;
      req_addr  = '0;
      req_data  = '0;
      set_req(0, 5'd0, 32'h11);
      set_req(1, 5'd0, 32'h22);
      set_req(2, 5'd0, 32'h33);

      // Reset held two cycles with all requesters valid
      for (int c = 0; c < 2; c++) begin
         cyc();
         chk("rst_ready", 32'(req_ready), 32'h0);
         chk("rst_we", 32'(we), 32'h0);
         chk("rst_waddr", 32'(wAddr), 32'h0);
         chk("rst_wdata", wData, 32'h0);
         chk("rst_pend", pend_mask, 32'h0);
         chk("rst_lg", 32'(last_grant), 32'h0);
      end
      req_valid = '0;
      rst = 1'b0;
      cyc();

      // Single write
      set_req(0, 5'd5, 32'hDEADBEEF);
      req_valid = 3'b001;
      #1;
      chk("single_ready", 32'(req_ready), 32'h1);
      chk("single_pend_T", pend_mask, 32'h20);
      cyc();
      req_valid = '0;
      #1;
      chk("single_we", 32'(we), 32'h1);
      chk("single_waddr", 32'(wAddr), 32'd5);
      chk("single_wdata", wData, 32'hDEADBEEF);
      chk("single_pend_T1", pend_mask, 32'h20);
      chk("single_lg", 32'(last_grant), 32'h1);
      cyc();
      chk("single_we_off", 32'(we), 32'h0);
      chk("single_pend_T2", pend_mask, 32'h0);
      chk("single_rf5", rf[5], 32'hDEADBEEF);

      // Write to $0 consumes the slot but never asserts we
      set_req(1, 5'd0, 32'h1234);
      req_valid = 3'b010;
      #1;
      chk("r0_ready", 32'(req_ready), 32'h2);
      chk("r0_pend_T", pend_mask, 32'h0);
      cyc();
      req_valid = '0;
      #1;
      chk("r0_we", 32'(we), 32'h0);
      chk("r0_wdata", wData, 32'h1234);
      chk("r0_pend_T1", pend_mask, 32'h0);
      chk("r0_lg", 32'(last_grant), 32'h2);

      // Contention from a fresh priority state
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      set_req(0, 5'd1, 32'h100);
      set_req(1, 5'd2, 32'h200);
      set_req(2, 5'd3, 32'h300);
      req_valid = 3'b111;
      prev_a = 5'd0;
      for (int k = 0; k < 6; k++) begin
         #1;
`ifdef REGFILE_ARB_RR_EN
         exp_g = NREQ'(1 << (k % 3));
`else
         exp_g = 3'b001;
`endif
         chk($sformatf("cont_grant%0d", k), 32'(req_ready), 32'(exp_g));
         chk($sformatf("cont_pend%0d", k), pend_mask, 32'hE);
         if (k > 0) begin
            chk($sformatf("cont_we%0d", k), 32'(we), 32'h1);
            chk($sformatf("cont_waddr%0d", k), 32'(wAddr), 32'(prev_a));
         end
         prev_a = (exp_g == 3'b001) ? 5'd1 : (exp_g == 3'b010) ? 5'd2 : 5'd3;
         cyc();
      end
      // Drain: each requester drops valid only after its own handshake
      n = 0;
      while (req_valid != '0 && n < 10) begin
         #1;
         exp_g = req_valid & ~req_ready;
         cyc();
         req_valid = exp_g;
         n++;
      end
      chk("drain_done", 32'(req_valid), 32'h0);

      // Same-register collision, fresh from reset
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      set_req(0, 5'd7, 32'hA);
      set_req(2, 5'd7, 32'hB);
      req_valid = 3'b101;
      #1;
      chk("coll_ready0", 32'(req_ready), 32'h1);
      chk("coll_pend0", pend_mask, 32'h80);
      cyc();
      req_valid = 3'b100;
      #1;
      chk("coll_ready1", 32'(req_ready), 32'h4);
      chk("coll_wdata_A", wData, 32'hA);
      chk("coll_pend1", pend_mask, 32'h80);
      cyc();
      req_valid = '0;
      #1;
      chk("coll_we_B", 32'(we), 32'h1);
      chk("coll_wdata_B", wData, 32'hB);
      chk("coll_pend2", pend_mask, 32'h80);
      chk("coll_lg", 32'(last_grant), 32'h4);
      cyc();
      chk("coll_rf7", rf[7], 32'hB);
      chk("coll_pend3", pend_mask, 32'h0);

      // Reset while a write sits in the output register
      set_req(0, 5'd9, 32'h99);
      req_valid = 3'b001;
      #1;
      chk("mid_ready", 32'(req_ready), 32'h1);
      cyc();
      req_valid = '0;
      rst = 1'b1;
      #1;
      chk("mid_we_T1", 32'(we), 32'h1);
      chk("mid_waddr_T1", 32'(wAddr), 32'd9);
      chk("mid_ready_rst", 32'(req_ready), 32'h0);
      cyc();
      rst = 1'b0;
      #1;
      chk("mid_we_T2", 32'(we), 32'h0);
      chk("mid_waddr_T2", 32'(wAddr), 32'h0);
      chk("mid_lg_T2", 32'(last_grant), 32'h0);
      chk("mid_pend", pend_mask, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
